// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } md_state_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and async reset.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_q
);

   logic [CNT_W-1:0] r_q;
   logic             w_full;

   assign w_full = &r_q;
   assign o_q    = r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (i_clr) begin
         r_q <= '0;
      end else if (i_inc && !w_full) begin
         r_q <= r_q + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage pipeline, with a
// hold FSM for the iterative mul/div unit and perf counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             ResultSrcE0,
   input  logic             PCSrcE,
   input  logic             md_start,
   input  logic             md_done,
   input  logic             cnt_clr,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             md_err,
   output logic [CNT_W-1:0] cnt_lw,
   output logic [CNT_W-1:0] cnt_br,
   output logic [CNT_W-1:0] cnt_md
);

   localparam int TO_W =
      (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST =
      TO_W'(MD_TIMEOUT - 1);

   md_state_e       r_state;
   md_state_e       w_state_nxt;
   logic [TO_W-1:0] r_to_cnt;
   logic            r_md_err;
   logic            w_timeout;
   logic            w_md_hold;
   logic            w_lw_stall;
   logic            w_lw_win;
   logic            w_br_win;
   fwd_sel_e        w_fwd_a;
   fwd_sel_e        w_fwd_b;

   always_comb begin
      w_fwd_a = FWD_RF;
      if (RegWriteM && RdM != 5'd0 && RdM == Rs1E) begin
         w_fwd_a = FWD_M;
      end else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E) begin
         w_fwd_a = FWD_W;
      end
   end

   always_comb begin
      w_fwd_b = FWD_RF;
      if (RegWriteM && RdM != 5'd0 && RdM == Rs2E) begin
         w_fwd_b = FWD_M;
      end else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E) begin
         w_fwd_b = FWD_W;
      end
   end

   assign ForwardAE = w_fwd_a;
   assign ForwardBE = w_fwd_b;

   assign w_lw_stall = ResultSrcE0 && RdE != 5'd0 &&
                       (RdE == Rs1D || RdE == Rs2D);
   assign w_timeout  = (r_state == MD_WAIT) &&
                       (r_to_cnt == TO_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_md_hold   = 1'b0;
      unique case (r_state)
         RUN: begin
            w_md_hold = md_start && !md_done;
            if (w_md_hold) begin
               w_state_nxt = MD_WAIT;
            end
         end
         MD_WAIT: begin
            w_md_hold = !md_done && !w_timeout;
            if (md_done || w_timeout) begin
               w_state_nxt = RUN;
            end
         end
         default: w_state_nxt = RUN;
      endcase
   end

   // md hold outranks a taken branch, which outranks load-use
   assign w_br_win = !w_md_hold && PCSrcE;
   assign w_lw_win = !w_md_hold && !PCSrcE && w_lw_stall;

   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushM = 1'b0;
      unique case (1'b1)
         w_md_hold: begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
         end
         w_br_win: begin
            FlushD = 1'b1;
            FlushE = 1'b1;
         end
         w_lw_win: begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= RUN;
         r_to_cnt <= '0;
         r_md_err <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_md_err <= r_md_err | w_timeout;
         if (r_state == MD_WAIT && w_state_nxt == MD_WAIT) begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end else begin
            r_to_cnt <= '0;
         end
      end
   end

   assign md_err = r_md_err;

   sat_counter #(.CNT_W(CNT_W)) u_cnt_lw (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_lw_win),
      .i_clr (cnt_clr),
      .o_q   (cnt_lw)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cnt_br (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_br_win),
      .i_clr (cnt_clr),
      .o_q   (cnt_br)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cnt_md (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_md_hold),
      .i_clr (cnt_clr),
      .o_q   (cnt_md)
   );

endmodule
